// File: rtl/rob_commit_unit_pkg.sv
// rob_commit_unit_pkg: shared instruction, broadcast and buffer-entry types for the retirement buffer.
package rob_commit_unit_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
  } pci_t;
  typedef struct packed {
    logic            rdy;
    pci_t            pc_info;
    logic [XLEN-1:0] data;
  } sal2_t;
  typedef struct packed {
    logic valid;
    logic done;
    pci_t pci;
  } reg_entry_t;
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} rob_state_t;
endpackage

// File: rtl/rob_commit_unit_if.sv
// rob_commit_unit_if: dispatch, writeback, control and commit-broadcast signals of the retirement buffer.
interface rob_commit_unit_if #(
  parameter int SIZE = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int WIDTH = 32
) ();
  import rob_commit_unit_pkg::*;
  localparam int AW = $clog2(SIZE);
  logic                               alloc_valid;
  pci_t                               alloc_pci;
  logic                               alloc_ready;
  logic [AW-1:0]                      alloc_tag;
  logic                               wb_valid;
  logic [AW-1:0]                      wb_tag;
  logic [WIDTH-1:0]                   wb_data;
  logic                               flush;
  logic                               halt;
  logic                               commit;
  sal2_t [SIZE-1:0]                   rdest;
  logic [SIZE-1:0][4:0]               rd_bus;
  logic [COMMIT_WIDTH-1:0]            rf_we;
  logic [COMMIT_WIDTH-1:0][4:0]       rf_rd;
  logic [COMMIT_WIDTH-1:0][WIDTH-1:0] rf_data;
  modport master (
    output alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush, halt,
    input  alloc_ready, alloc_tag, commit, rdest, rd_bus, rf_we, rf_rd, rf_data
  );
  modport slave (
    input  alloc_valid, alloc_pci, wb_valid, wb_tag, wb_data, flush, halt,
    output alloc_ready, alloc_tag, commit, rdest, rd_bus, rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/rob_commit_unit_retire_select.sv
// rob_retire_select: counts consecutive valid&done entries from head (with wrap), capped at COMMIT_WIDTH.
module rob_retire_select #(
  parameter int SIZE = 8,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic [SIZE-1:0]                               i_valid,
  input  logic [SIZE-1:0]                               i_done,
  input  logic [$clog2(SIZE)-1:0]                       i_head,
  input  logic                                          i_en,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]             o_k,
  output logic [COMMIT_WIDTH-1:0]                       o_lane,
  output logic [COMMIT_WIDTH-1:0][$clog2(SIZE)-1:0]     o_idx
);
  localparam int AW = $clog2(SIZE);
  localparam int KW = $clog2(COMMIT_WIDTH + 1);
  logic w_run;
  always_comb begin
    o_k = '0;
    o_lane = '0;
    o_idx = '0;
    w_run = i_en;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      o_idx[j] = i_head + AW'(j);
      w_run = w_run && i_valid[o_idx[j]] && i_done[o_idx[j]];
      o_lane[j] = w_run;
      o_k = w_run ? KW'(j + 1) : o_k;
    end
  end
endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order retirement buffer driving regfile write ports and the commit broadcast.
// Define COMMIT_GAP_EN to force an idle cycle after every commit pulse.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  rob_commit_unit_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(COMMIT_WIDTH + 1);
  rob_state_t                         r_state;
  logic                               r_halt_pend;
  logic                               r_commit;
  logic [PW-1:0]                      r_head;
  logic [PW-1:0]                      r_tail;
  reg_entry_t                         r_ent [SIZE];
  logic [WIDTH-1:0]                   r_data [SIZE];
  sal2_t [SIZE-1:0]                   r_rdest;
  logic [SIZE-1:0][4:0]               r_rd_bus;
  logic [COMMIT_WIDTH-1:0]            r_rf_we;
  logic [COMMIT_WIDTH-1:0][4:0]       r_rf_rd;
  logic [COMMIT_WIDTH-1:0][WIDTH-1:0] r_rf_data;
  logic [PW-1:0]                      w_count;
  logic [SIZE-1:0]                    w_valid;
  logic [SIZE-1:0]                    w_done;
  logic [KW-1:0]                      w_k;
  logic [COMMIT_WIDTH-1:0]            w_lane;
  logic [COMMIT_WIDTH-1:0][AW-1:0]    w_idx;
  logic                               w_full;
  logic                               w_ready;
  logic                               w_alloc;
  logic                               w_clear;
  logic                               w_ret_en;
  always_comb begin
    w_valid = '0;
    w_done = '0;
    for (int s = 0; s < SIZE; s++) begin
      w_valid[s] = r_ent[s].valid;
      w_done[s] = r_ent[s].done;
    end
  end
  // wrap bit makes tail-head the occupancy directly, so full is count==SIZE
  assign w_count = r_tail - r_head;
  assign w_full  = w_count == PW'(SIZE);
  assign w_ready = r_state != FLUSH && !w_full;
  assign w_alloc = bus.alloc_valid && w_ready;
  assign w_clear = (r_state == RUN && bus.flush) || r_state == FLUSH;
`ifdef COMMIT_GAP_EN
  assign w_ret_en = r_state == RUN && !bus.flush && !r_commit;
`else
  assign w_ret_en = r_state == RUN && !bus.flush;
`endif
  rob_retire_select #(.SIZE(SIZE), .COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
    .i_valid (w_valid),
    .i_done  (w_done),
    .i_head  (r_head[AW-1:0]),
    .i_en    (w_ret_en),
    .o_k     (w_k),
    .o_lane  (w_lane),
    .o_idx   (w_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_halt_pend <= 1'b0;
      r_commit <= 1'b0;
      r_head <= '0;
      r_tail <= '0;
      r_rdest <= '0;
      r_rd_bus <= '0;
      r_rf_we <= '0;
      r_rf_rd <= '0;
      r_rf_data <= '0;
      for (int s = 0; s < SIZE; s++) begin
        r_ent[s] <= '0;
        r_data[s] <= '0;
      end
    end else begin
      r_commit <= w_k != '0;
      r_rdest <= '0;
      r_rd_bus <= '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        r_rf_we[j] <= w_lane[j] && r_ent[w_idx[j]].pci.rd != 5'd0;
        r_rf_rd[j] <= w_lane[j] ? r_ent[w_idx[j]].pci.rd : 5'd0;
        r_rf_data[j] <= w_lane[j] ? r_data[w_idx[j]] : '0;
        if (w_lane[j]) begin
          r_rdest[w_idx[j]] <= '{rdy: 1'b1, pc_info: r_ent[w_idx[j]].pci, data: XLEN'(r_data[w_idx[j]])};
          r_rd_bus[w_idx[j]] <= r_ent[w_idx[j]].pci.rd;
        end
      end
      // a halt arriving with flush is remembered so FLUSH still lands in HALTED
      r_halt_pend <= r_state == RUN && bus.flush && bus.halt;
      r_state <= r_state == FLUSH ? (r_halt_pend ? HALTED : RUN) :
                 r_state == HALTED ? HALTED :
                 bus.flush ? FLUSH : bus.halt ? HALTED : RUN;
      if (w_clear) begin
        r_head <= '0;
        r_tail <= '0;
        for (int s = 0; s < SIZE; s++) r_ent[s] <= '0;
      end else begin
        if (bus.wb_valid && r_ent[bus.wb_tag].valid) begin
          r_ent[bus.wb_tag].done <= 1'b1;
          r_data[bus.wb_tag] <= bus.wb_data;
        end
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
          if (w_lane[j]) begin
            r_ent[w_idx[j]].valid <= 1'b0;
            r_ent[w_idx[j]].done <= 1'b0;
          end
        end
        r_head <= r_head + PW'(w_k);
        if (w_alloc) begin
          r_ent[r_tail[AW-1:0]] <= '{valid: 1'b1, done: 1'b0, pci: bus.alloc_pci};
          r_tail <= r_tail + PW'(1);
        end
      end
    end
  end
  assign bus.alloc_ready = w_ready;
  assign bus.alloc_tag   = r_tail[AW-1:0];
  assign bus.commit      = r_commit;
  assign bus.rdest       = r_rdest;
  assign bus.rd_bus      = r_rd_bus;
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_data     = r_rf_data;
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed self-checking bench for rob_commit_unit (SIZE=8, COMMIT_WIDTH=2).
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  rob_commit_unit_if #(.SIZE(8), .COMMIT_WIDTH(2), .WIDTH(32)) bus ();
  rob_commit_unit #(.SIZE(8), .COMMIT_WIDTH(2), .WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_pci = '0;
    bus.wb_valid = 1'b0;
    bus.wb_tag = '0;
    bus.wb_data = '0;
    bus.flush = 1'b0;
    bus.halt = 1'b0;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic alloc(input logic [4:0] a_rd, input logic [31:0] a_pc, input logic [2:0] exp_tag, input string tag);
    bus.alloc_valid = 1'b1;
    bus.alloc_pci = '{pc: a_pc, rd: a_rd};
    check(tag, 64'(bus.alloc_tag), 64'(exp_tag));
    tick();
    bus.alloc_valid = 1'b0;
  endtask
  task automatic wb(input logic [2:0] t, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_tag = t;
    bus.wb_data = d;
    tick();
    bus.wb_valid = 1'b0;
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check("rst_commit", 64'(bus.commit), 64'(0));
    check("rst_ready", 64'(bus.alloc_ready), 64'(1));
    check("rst_tag", 64'(bus.alloc_tag), 64'(0));
    check("rst_we", 64'(bus.rf_we), 64'(0));
    check("rst_rdest", 64'(|bus.rdest), 64'(0));
    check("rst_rfdata", 64'(|bus.rf_data), 64'(0));
    tick();
    rst_n = 1'b1;
    // two entries completed out of order retire together
    alloc(5'd1, 32'h0, 3'd0, "t1_tag0");
    alloc(5'd2, 32'h4, 3'd1, "t1_tag1");
    wb(3'd1, 32'd7);
    check("t1_pre", 64'(bus.commit), 64'(0));
    wb(3'd0, 32'd5);
    tick();
    check("t1_commit", 64'(bus.commit), 64'(1));
    check("t1_rdy0", 64'(bus.rdest[0].rdy), 64'(1));
    check("t1_rdy1", 64'(bus.rdest[1].rdy), 64'(1));
    check("t1_we", 64'(bus.rf_we), 64'(3));
    check("t1_rd0", 64'(bus.rf_rd[0]), 64'(1));
    check("t1_rd1", 64'(bus.rf_rd[1]), 64'(2));
    check("t1_data0", 64'(bus.rf_data[0]), 64'(5));
    check("t1_data1", 64'(bus.rf_data[1]), 64'(7));
    check("t1_rdbus1", 64'(bus.rd_bus[1]), 64'(2));
    check("t1_rdest_data1", 64'(bus.rdest[1].data), 64'(7));
    rst_n = 1'b0;
    #1;
    check("mid_rst_commit", 64'(bus.commit), 64'(0));
    check("mid_rst_we", 64'(bus.rf_we), 64'(0));
    // full buffer: freed slot becomes allocatable only the cycle after retire
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check("t2_ready", 64'(bus.alloc_ready), 64'(1));
      alloc(5'(i + 1), 32'(4 * i), 3'(i), "t2_tag");
    end
    check("t2_full", 64'(bus.alloc_ready), 64'(0));
    bus.alloc_valid = 1'b1;
    bus.alloc_pci = '{pc: 32'h100, rd: 5'd9};
    wb(3'd0, 32'h100);
    check("t2_same_cycle", 64'(bus.alloc_ready), 64'(0));
    tick();
    check("t2_next_ready", 64'(bus.alloc_ready), 64'(1));
    check("t2_next_tag", 64'(bus.alloc_tag), 64'(0));
    check("t2_commit", 64'(bus.commit), 64'(1));
    check("t2_we", 64'(bus.rf_we), 64'(1));
    check("t2_rd0", 64'(bus.rf_rd[0]), 64'(1));
    check("t2_data0", 64'(bus.rf_data[0]), 64'(32'h100));
    tick();
    bus.alloc_valid = 1'b0;
    check("t2_refull", 64'(bus.alloc_ready), 64'(0));
    check("t2_no_commit", 64'(bus.commit), 64'(0));
    // wrap: head at 6, new entries land in slots 0..3
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 32'(4 * i), 3'(i), "t3_fill_tag");
    for (int i = 0; i < 6; i++) wb(3'(i), 32'(32'h50 + i));
    repeat (12) tick();
    for (int i = 0; i < 4; i++) alloc(5'(11 + i), 32'(32'h200 + 4 * i), 3'(i), "t3_wrap_tag");
    wb(3'd7, 32'h67);
    wb(3'd6, 32'h66);
    wb(3'd1, 32'h61);
    check("t3_g1_commit", 64'(bus.commit), 64'(1));
    check("t3_g1_rd0", 64'(bus.rf_rd[0]), 64'(7));
    check("t3_g1_rd1", 64'(bus.rf_rd[1]), 64'(8));
    check("t3_g1_data0", 64'(bus.rf_data[0]), 64'(32'h66));
    check("t3_g1_data1", 64'(bus.rf_data[1]), 64'(32'h67));
    check("t3_g1_rdy7", 64'(bus.rdest[7].rdy), 64'(1));
    wb(3'd0, 32'h60);
    check("t3_gap_commit", 64'(bus.commit), 64'(0));
    wb(3'd3, 32'h63);
    check("t3_g2_rd0", 64'(bus.rf_rd[0]), 64'(11));
    check("t3_g2_rd1", 64'(bus.rf_rd[1]), 64'(12));
    check("t3_g2_data0", 64'(bus.rf_data[0]), 64'(32'h60));
    wb(3'd2, 32'h62);
    tick();
    check("t3_g3_commit", 64'(bus.commit), 64'(1));
    check("t3_g3_rd0", 64'(bus.rf_rd[0]), 64'(13));
    check("t3_g3_rd1", 64'(bus.rf_rd[1]), 64'(14));
    check("t3_g3_data1", 64'(bus.rf_data[1]), 64'(32'h63));
    // flush discards in-flight entries
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 1), 32'(4 * i), 3'(i), "t4_tag");
    wb(3'd1, 32'h11);
    wb(3'd2, 32'h22);
    check("t4_pre", 64'(bus.commit), 64'(0));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t4_flush_ready", 64'(bus.alloc_ready), 64'(0));
    check("t4_flush_commit", 64'(bus.commit), 64'(0));
    wb(3'd2, 32'h99);
    check("t4_after_ready", 64'(bus.alloc_ready), 64'(1));
    check("t4_after_tag", 64'(bus.alloc_tag), 64'(0));
    tick();
    check("t4_after_commit", 64'(bus.commit), 64'(0));
    // x0 destination retires without a regfile write
    do_reset();
    alloc(5'd0, 32'h40, 3'd0, "t5_tag");
    wb(3'd0, 32'hDEAD);
    tick();
    check("t5_commit", 64'(bus.commit), 64'(1));
    check("t5_rdy", 64'(bus.rdest[0].rdy), 64'(1));
    check("t5_data", 64'(bus.rdest[0].data), 64'(32'hDEAD));
    check("t5_pc", 64'(bus.rdest[0].pc_info.pc), 64'(32'h40));
    check("t5_we", 64'(bus.rf_we), 64'(0));
    // commit pulse pattern for four completed entries
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 32'(4 * i), 3'(i), "t6_tag");
    wb(3'd3, 32'h33);
    wb(3'd2, 32'h22);
    wb(3'd1, 32'h11);
    wb(3'd0, 32'h10);
    tick();
    check("t6_c1", 64'(bus.commit), 64'(1));
    check("t6_c1_rd0", 64'(bus.rf_rd[0]), 64'(1));
    tick();
`ifdef COMMIT_GAP_EN
    check("t6_c2", 64'(bus.commit), 64'(0));
    tick();
    check("t6_c3", 64'(bus.commit), 64'(1));
    check("t6_c3_rd0", 64'(bus.rf_rd[0]), 64'(3));
    check("t6_c3_we", 64'(bus.rf_we), 64'(3));
    tick();
    check("t6_c4", 64'(bus.commit), 64'(0));
`else
    check("t6_c2", 64'(bus.commit), 64'(1));
    check("t6_c2_rd0", 64'(bus.rf_rd[0]), 64'(3));
    check("t6_c2_we", 64'(bus.rf_we), 64'(3));
    tick();
    check("t6_c3", 64'(bus.commit), 64'(0));
`endif
    // halt: retire decided in the halt cycle completes, then nothing retires
    do_reset();
    alloc(5'd1, 32'h0, 3'd0, "t7_tag0");
    alloc(5'd2, 32'h4, 3'd1, "t7_tag1");
    wb(3'd1, 32'h71);
    wb(3'd0, 32'h70);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("t7_last_commit", 64'(bus.commit), 64'(1));
    check("t7_last_we", 64'(bus.rf_we), 64'(3));
    check("t7_halt_ready", 64'(bus.alloc_ready), 64'(1));
    alloc(5'd3, 32'h8, 3'd2, "t7_tag2");
    wb(3'd2, 32'h72);
    tick();
    check("t7_halted_c1", 64'(bus.commit), 64'(0));
    tick();
    check("t7_halted_c2", 64'(bus.commit), 64'(0));
    check("t7_halted_rdy", 64'(bus.rdest[2].rdy), 64'(0));
    // flush together with halt: FLUSH, then HALTED
    do_reset();
    alloc(5'd1, 32'h0, 3'd0, "t8_tag0");
    bus.flush = 1'b1;
    bus.halt = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.halt = 1'b0;
    check("t8_flush_ready", 64'(bus.alloc_ready), 64'(0));
    tick();
    check("t8_ready", 64'(bus.alloc_ready), 64'(1));
    check("t8_tag", 64'(bus.alloc_tag), 64'(0));
    alloc(5'd1, 32'h0, 3'd0, "t8_tag_new");
    wb(3'd0, 32'h5);
    tick();
    check("t8_c1", 64'(bus.commit), 64'(0));
    tick();
    check("t8_c2", 64'(bus.commit), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
